interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Sequences interrupt entry and RTI return for the 5-stage pipeline: freezes fetch, drains in-flight work,
//  pushes return PC and flags to the stack, reads the handler vector, and redirects the PC.
//  RTI reverses this by popping flags and PC and restoring them.
//  Sits beside fetch and data-memory stages and shares the data-memory port via a req/gnt handshake.
// PARAMETERS
//  PC_W         32      program-counter width; pushed/popped as two 16-bit words, hi word first on push
//  DATA_W       16      memory word width
//  VECTOR_ADDR  16'h0   data-memory address of vector hi word; lo word is at VECTOR_ADDR+1
//  DRAIN_CYCLES 3       cycles to let decode/ALU/memory stages retire before stack access (>=1)
// PORTS
//  clk                 in   1       rising-edge clock
//  reset               in   1       asynchronous, active-low reset
//  irq                 in   1       external interrupt request, level or pulse; rising edge latched
//  rti                 in   1       1-cycle pulse: RTI decoded in decode stage
//  branch_pending      in   1       jump resolving in ALU stage; interrupt acceptance deferred while 1
//  cur_pc              in   PC_W    address of next instruction to fetch (return address)
//  cur_flags           in   3       current CCR {C,N,Z}
//  stall_fetch         out  1       hold PC and fetch buffer
//  flush               out  1       inject NOP into decode
//  mem_req             out  1       data-memory port request; held until mem_gnt
//  mem_op              out  2       00 PUSH, 01 POP, 10 READ(mem_addr); 11 unused
//  mem_addr            out  DATA_W  address for READ, else 0
//  mem_wdata           out  DATA_W  data for PUSH
//  mem_gnt             in   1       port granted this cycle; mem_rdata valid in same cycle
//  mem_rdata           in   DATA_W  POP/READ data
//  pc_load             out  1       1-cycle pulse: fetch loads pc_load_value
//  pc_load_value       out  PC_W    new PC
//  flags_restore       out  1       1-cycle pulse: CCR <= flags_restore_value
//  flags_restore_value out  3       restored flags
//  in_isr              out  1       handler active; further interrupts masked
//  busy                out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, pending=0, in_isr=0; all outputs 0.
//   Applies mid-sequence: any partial push or pop is abandoned, and mem_req drops immediately.
//  pending: set on irq rising edge (irq_q registered); cleared on IDLE->I_DRAIN. A new edge while
//   pending=1 is absorbed (no counting).
//  IDLE:     rti & in_isr -> R_DRAIN. rti & !in_isr is ignored (NOP).
//            Else pending & !in_isr & !branch_pending -> I_DRAIN; ret_pc <= cur_pc at this edge.
//            rti has priority over pending in the same cycle.
//  I_DRAIN/R_DRAIN: stall_fetch=1, flush=1 for DRAIN_CYCLES cycles, counted by cnt.
//            On the last cycle, I_DRAIN captures ret_flags <= cur_flags.
//  I_PUSH_HI -> I_PUSH_LO -> I_PUSH_FL: mem_req=1, mem_op=PUSH.
//            wdata = ret_pc[31:16], ret_pc[15:0], {13'b0,ret_flags} in turn.
//  I_VEC_HI -> I_VEC_LO: mem_op=READ, mem_addr=VECTOR_ADDR then VECTOR_ADDR+1; register mem_rdata.
//  Each memory state advances only on a mem_gnt cycle. mem_req, op, addr and wdata stay stable until gnt.
//  I_LOAD: pc_load=1, pc_load_value={vec_hi,vec_lo}; in_isr<=1 -> IDLE.
//  R_POP_FL -> R_POP_LO -> R_POP_HI: mem_op=POP, gnt-advanced.
//            Capture flags=mem_rdata[2:0], then pc lo, then pc hi.
//  R_LOAD: pc_load=1, flags_restore=1 with popped values; in_isr<=0 -> IDLE.
//   An interrupt pending since ISR entry is accepted on the next IDLE cycle.
//  stall_fetch=1 in every non-IDLE state except *_LOAD. busy=1 in every non-IDLE state.
//  Latency with mem_gnt tied 1: irq edge to pc_load = 1 + DRAIN_CYCLES + 5 + 1 cycles (10 at defaults).
//   RTI to pc_load = DRAIN_CYCLES + 4 (7 at defaults).
// TESTING
//  1. Defaults, gnt=1, cur_pc=32'h0000_0124, flags=3'b101, mem[0..1]=16'h0000,16'h0200, irq pulse.
//     -> pushes 16'h0000, 16'h0124, 16'h0005; reads addr 0 then 1.
//     -> pc_load with 32'h0000_0200 exactly 10 cycles after the edge; in_isr=1.
//  2. Case 1, then rti with stack 16'h0005, 16'h0124, 16'h0000 (pop order).
//     -> 7 cycles later pc_load=32'h0000_0124, flags_restore=3'b101, in_isr=0.
//  3. Second irq during ISR: no entry until RTI's R_LOAD.
//     -> then I_DRAIN starts on the following cycle. Two extra irq edges yield one entry.
//  4. gnt withheld 4 cycles in I_PUSH_LO.
//     -> mem_req, op=PUSH, wdata=16'h0124 held constant for 4 cycles; sequence resumes on gnt.
//  5. irq while branch_pending=1 for 3 cycles -> stays IDLE.
//     -> enters I_DRAIN the cycle after branch_pending falls; rti with in_isr=0 is ignored.
//  6. Assert reset during I_VEC_HI.
//     -> all outputs 0 asynchronously, in_isr=0, pending=0; no pc_load after release.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer for the 5-stage pipeline.
// Freezes fetch, drains the pipe, pushes or pops PC and flags over a shared data-memory port, then redirects fetch.
module interrupt_sequencer #(
    parameter int                PC_W         = 32,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] VECTOR_ADDR  = '0,
    parameter int                DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    input  logic              rti,
    input  logic              branch_pending,
    input  logic [PC_W-1:0]   cur_pc,
    input  logic [2:0]        cur_flags,
    output logic              stall_fetch,
    output logic              flush,
    output logic              mem_req,
    output logic [1:0]        mem_op,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_value,
    output logic              flags_restore,
    output logic [2:0]        flags_restore_value,
    output logic              in_isr,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE,
        I_DRAIN,
        I_PUSH_HI,
        I_PUSH_LO,
        I_PUSH_FL,
        I_VEC_HI,
        I_VEC_LO,
        I_LOAD,
        R_DRAIN,
        R_POP_FL,
        R_POP_LO,
        R_POP_HI,
        R_LOAD
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    localparam int                CNT_W          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [DATA_W-1:0] VECTOR_ADDR_LO = VECTOR_ADDR + DATA_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               pending_q, pending_d;
    logic               in_isr_q, in_isr_d;
    logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
    logic [2:0]         ret_flags_q, ret_flags_d;
    logic [DATA_W-1:0]  word_hi_q, word_hi_d;
    logic [DATA_W-1:0]  word_lo_q, word_lo_d;
    logic [2:0]         pop_flags_q, pop_flags_d;
    logic               irq_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
            pending_q   <= 1'b0;
            in_isr_q    <= 1'b0;
            ret_pc_q    <= '0;
            ret_flags_q <= '0;
            word_hi_q   <= '0;
            word_lo_q   <= '0;
            pop_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            in_isr_q    <= in_isr_d;
            ret_pc_q    <= ret_pc_d;
            ret_flags_q <= ret_flags_d;
            word_hi_q   <= word_hi_d;
            word_lo_q   <= word_lo_d;
            pop_flags_q <= pop_flags_d;
        end
    end

    // word_hi/word_lo hold the vector on entry and the popped PC on return; the two never overlap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_d       = irq;
        in_isr_d    = in_isr_q;
        ret_pc_d    = ret_pc_q;
        ret_flags_d = ret_flags_q;
        word_hi_d   = word_hi_q;
        word_lo_d   = word_lo_q;
        pop_flags_d = pop_flags_q;

        irq_rise  = irq & ~irq_q;
        pending_d = pending_q | irq_rise;

        stall_fetch         = 1'b0;
        flush               = 1'b0;
        mem_req             = 1'b0;
        mem_op              = OP_PUSH;
        mem_addr            = '0;
        mem_wdata           = '0;
        pc_load             = 1'b0;
        pc_load_value       = '0;
        flags_restore       = 1'b0;
        flags_restore_value = '0;
        busy                = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (rti && in_isr_q) begin
                    state_d = R_DRAIN;
                    cnt_d   = '0;
                end else if (pending_q && !in_isr_q && !branch_pending) begin
                    state_d   = I_DRAIN;
                    cnt_d     = '0;
                    ret_pc_d  = cur_pc;
                    pending_d = irq_rise;
                end
            end
            I_DRAIN, R_DRAIN: begin
                stall_fetch = 1'b1;
                flush       = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (state_q == I_DRAIN) begin
                        ret_flags_d = cur_flags;
                        state_d     = I_PUSH_HI;
                    end else begin
                        state_d = R_POP_FL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            I_PUSH_HI: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_wdata   = ret_pc_q[PC_W-1:DATA_W];
                if (mem_gnt) state_d = I_PUSH_LO;
            end
            I_PUSH_LO: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_wdata   = ret_pc_q[DATA_W-1:0];
                if (mem_gnt) state_d = I_PUSH_FL;
            end
            I_PUSH_FL: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_wdata   = {{(DATA_W-3){1'b0}}, ret_flags_q};
                if (mem_gnt) state_d = I_VEC_HI;
            end
            I_VEC_HI: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_op      = OP_READ;
                mem_addr    = VECTOR_ADDR;
                if (mem_gnt) begin
                    word_hi_d = mem_rdata;
                    state_d   = I_VEC_LO;
                end
            end
            I_VEC_LO: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_op      = OP_READ;
                mem_addr    = VECTOR_ADDR_LO;
                if (mem_gnt) begin
                    word_lo_d = mem_rdata;
                    state_d   = I_LOAD;
                end
            end
            I_LOAD: begin
                pc_load       = 1'b1;
                pc_load_value = {word_hi_q, word_lo_q};
                in_isr_d      = 1'b1;
                state_d       = IDLE;
            end
            R_POP_FL: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_op      = OP_POP;
                if (mem_gnt) begin
                    pop_flags_d = mem_rdata[2:0];
                    state_d     = R_POP_LO;
                end
            end
            R_POP_LO: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_op      = OP_POP;
                if (mem_gnt) begin
                    word_lo_d = mem_rdata;
                    state_d   = R_POP_HI;
                end
            end
            R_POP_HI: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_op      = OP_POP;
                if (mem_gnt) begin
                    word_hi_d = mem_rdata;
                    state_d   = R_LOAD;
                end
            end
            R_LOAD: begin
                pc_load             = 1'b1;
                pc_load_value       = {word_hi_q, word_lo_q};
                flags_restore       = 1'b1;
                flags_restore_value = pop_flags_q;
                in_isr_d            = 1'b0;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_isr = in_isr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed plus randomized bench for interrupt_sequencer with a stack/vector memory responder.
// Expectations come from the entry/return rules: push order, vector reads, latencies and restored state.
module tb_interrupt_sequencer;

    localparam int         DRAIN   = 3;
    localparam logic [15:0] VA     = 16'h0000;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam int         IRQ_LAT = 1 + DRAIN + 5 + 1;
    localparam int         RTI_LAT = DRAIN + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        irq = 1'b0;
    logic        rti = 1'b0;
    logic        branch_pending = 1'b0;
    logic [31:0] cur_pc = '0;
    logic [2:0]  cur_flags = '0;
    logic        stall_fetch, flush, mem_req, mem_gnt, pc_load, flags_restore, in_isr, busy;
    logic [1:0]  mem_op;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pc_load_value;
    logic [2:0]  flags_restore_value;

    logic        gnt_en = 1'b1;
    logic        rand_gnt = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] stack_mem [16];
    logic [3:0]  sp;
    logic [15:0] vec_mem [2];
    logic [15:0] push_log [$];
    logic [15:0] read_log [$];

    interrupt_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .irq                 (irq),
        .rti                 (rti),
        .branch_pending      (branch_pending),
        .cur_pc              (cur_pc),
        .cur_flags           (cur_flags),
        .stall_fetch         (stall_fetch),
        .flush               (flush),
        .mem_req             (mem_req),
        .mem_op              (mem_op),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_gnt             (mem_gnt),
        .mem_rdata           (mem_rdata),
        .pc_load             (pc_load),
        .pc_load_value       (pc_load_value),
        .flags_restore       (flags_restore),
        .flags_restore_value (flags_restore_value),
        .in_isr              (in_isr),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_en;

    always_comb begin
        mem_rdata = 16'h0;
        if (mem_op == OP_POP && sp != 4'd0) mem_rdata = stack_mem[sp - 4'd1];
        else if (mem_op == OP_READ) begin
            if (mem_addr == VA) mem_rdata = vec_mem[0];
            else if (mem_addr == VA + 16'd1) mem_rdata = vec_mem[1];
            else mem_rdata = 16'hDEAD;
        end
    end

    // Stack memory model; every granted transaction is logged for later comparison.
    always @(posedge clk or negedge reset) begin
        if (!reset) sp <= '0;
        else if (mem_gnt) begin
            case (mem_op)
                OP_PUSH: begin
                    stack_mem[sp] <= mem_wdata;
                    sp <= sp + 4'd1;
                    push_log.push_back(mem_wdata);
                end
                OP_POP:  sp <= sp - 4'd1;
                OP_READ: read_log.push_back(mem_addr);
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_gnt) gnt_en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pc_load(input int limit, output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < limit) begin
            step();
            irq = 1'b0;
            rti = 1'b0;
            lat++;
            if (pc_load === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_entry(input string tag, input logic [31:0] pc, input logic [2:0] fl,
                             input logic [15:0] vh, input logic [15:0] vl, input logic exact_lat);
        int   lat;
        logic seen;
        vec_mem[0] = vh;
        vec_mem[1] = vl;
        cur_pc     = pc;
        cur_flags  = fl;
        push_log.delete();
        read_log.delete();
        irq = 1'b1;
        wait_pc_load(300, lat, seen);
        check_output({tag, "_seen"}, seen, 1'b1);
        if (exact_lat) check_output({tag, "_lat"}, lat, IRQ_LAT);
        else check_output({tag, "_lat_min"}, lat >= IRQ_LAT, 1'b1);
        check_output({tag, "_vector"}, pc_load_value, {vh, vl});
        check_output({tag, "_npush"}, push_log.size(), 3);
        check_output({tag, "_push_hi"}, push_log[0], pc[31:16]);
        check_output({tag, "_push_lo"}, push_log[1], pc[15:0]);
        check_output({tag, "_push_fl"}, push_log[2], {13'b0, fl});
        check_output({tag, "_nread"}, read_log.size(), 2);
        check_output({tag, "_read0"}, read_log[0], VA);
        check_output({tag, "_read1"}, read_log[1], VA + 16'd1);
        step();
        check_output({tag, "_in_isr"}, in_isr, 1'b1);
        check_output({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_return(input string tag, input logic [31:0] pc, input logic [2:0] fl,
                              input logic exact_lat);
        int   lat;
        logic seen;
        rti = 1'b1;
        wait_pc_load(300, lat, seen);
        check_output({tag, "_seen"}, seen, 1'b1);
        if (exact_lat) check_output({tag, "_lat"}, lat, RTI_LAT);
        else check_output({tag, "_lat_min"}, lat >= RTI_LAT, 1'b1);
        check_output({tag, "_pc"}, pc_load_value, pc);
        check_output({tag, "_frestore"}, flags_restore, 1'b1);
        check_output({tag, "_flags"}, flags_restore_value, fl);
        step();
        check_output({tag, "_in_isr"}, in_isr, 1'b0);
        check_output({tag, "_sp"}, sp, 4'd0);
    endtask

    function automatic logic [11:0] ctl_vec();
        return {stall_fetch, flush, mem_req, mem_op, pc_load, flags_restore,
                flags_restore_value, in_isr, busy};
    endfunction

    initial begin
        int          lat, busy_seen, load_seen;
        logic        seen;
        logic [31:0] pc;
        logic [2:0]  fl;
        logic [15:0] vh, vl;

        // Reset state
        #1;
        check_output("rst_ctl", ctl_vec(), 12'h0);
        check_output("rst_pcval", pc_load_value, 32'h0);
        check_output("rst_wdata", {mem_addr, mem_wdata}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_output("post_rst_idle", {busy, in_isr}, 2'b00);

        // Case 1 and 2: basic entry and return with exact latencies
        run_entry("t1", 32'h0000_0124, 3'b101, 16'h0000, 16'h0200, 1'b1);
        run_return("t2", 32'h0000_0124, 3'b101, 1'b1);

        // Case 3: two irq edges inside the ISR give exactly one later entry
        run_entry("t3a", 32'h0000_0400, 3'b010, 16'h0000, 16'h0300, 1'b1);
        step();
        irq = 1'b1; step(); irq = 1'b0;
        repeat (3) step();
        irq = 1'b1; step(); irq = 1'b0;
        repeat (5) step();
        check_output("t3_masked_busy", busy, 1'b0);
        check_output("t3_masked_isr", in_isr, 1'b1);
        rti = 1'b1;
        wait_pc_load(50, lat, seen);
        check_output("t3_rload_seen", seen & flags_restore, 1'b1);
        check_output("t3_rload_lat", lat, RTI_LAT);
        check_output("t3_rload_pc", pc_load_value, 32'h0000_0400);
        step();
        check_output("t3_gap_idle", busy, 1'b0);
        step();
        check_output("t3_redrain", {busy, stall_fetch, flush}, 3'b111);
        wait_pc_load(50, lat, seen);
        check_output("t3_reentry_seen", seen, 1'b1);
        check_output("t3_reentry_vec", pc_load_value, 32'h0000_0300);
        step();
        run_return("t3b", 32'h0000_0400, 3'b010, 1'b0);
        busy_seen = 0;
        repeat (15) begin
            step();
            if (busy) busy_seen++;
        end
        check_output("t3_single_entry", busy_seen, 0);

        // Case 4: grant withheld for 4 cycles in the low-word push
        pc = {16'($urandom), 16'h0124};
        vec_mem[0] = 16'h0000;
        vec_mem[1] = 16'h0880;
        cur_pc = pc;
        cur_flags = 3'b011;
        push_log.delete();
        read_log.delete();
        irq = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            step();
            irq = 1'b0;
            lat++;
            if (mem_req && mem_op == OP_PUSH && push_log.size() == 1) seen = 1'b1;
        end
        check_output("t4_reach_lo", seen, 1'b1);
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("t4_hold", {mem_req, mem_op, mem_wdata}, {1'b1, OP_PUSH, 16'h0124});
            step();
        end
        check_output("t4_no_push", push_log.size(), 1);
        gnt_en = 1'b1;
        wait_pc_load(40, lat, seen);
        check_output("t4_seen", seen, 1'b1);
        check_output("t4_vec", pc_load_value, 32'h0000_0880);
        check_output("t4_push_lo", push_log[1], 16'h0124);
        check_output("t4_push_fl", push_log[2], 16'h0003);
        step();
        run_return("t4r", pc, 3'b011, 1'b1);

        // Case 5: rti outside ISR ignored; entry deferred while branch pending
        rti = 1'b1; step(); rti = 1'b0;
        check_output("t5_rti_ignored0", busy, 1'b0);
        step();
        check_output("t5_rti_ignored1", busy, 1'b0);
        vec_mem[0] = 16'h0001;
        vec_mem[1] = 16'h2345;
        cur_pc = 32'h0000_0777;
        cur_flags = 3'b110;
        branch_pending = 1'b1;
        irq = 1'b1;
        step(); irq = 1'b0;
        check_output("t5_defer0", busy, 1'b0);
        step();
        check_output("t5_defer1", busy, 1'b0);
        step();
        check_output("t5_defer2", busy, 1'b0);
        branch_pending = 1'b0;
        step();
        check_output("t5_enter", {busy, flush}, 2'b11);
        wait_pc_load(40, lat, seen);
        check_output("t5_vec", pc_load_value, 32'h0001_2345);
        step();
        run_return("t5r", 32'h0000_0777, 3'b110, 1'b1);

        // Randomized entry/return rounds with a stalling memory port
        rand_gnt = 1'b1;
        for (int r = 0; r < 6; r++) begin
            pc = $urandom;
            fl = 3'($urandom);
            vh = 16'($urandom);
            vl = 16'($urandom);
            run_entry("rnd_in", pc, fl, vh, vl, 1'b0);
            cur_pc = $urandom;
            cur_flags = 3'($urandom);
            repeat ($urandom_range(0, 4)) step();
            run_return("rnd_out", pc, fl, 1'b0);
        end
        rand_gnt = 1'b0;
        gnt_en = 1'b1;

        // Case 6: reset in I_VEC_HI with another irq pending
        vec_mem[0] = 16'h0000;
        vec_mem[1] = 16'h0500;
        irq = 1'b1; step(); irq = 1'b0;
        step(); step();
        irq = 1'b1; step(); irq = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (mem_req && mem_op == OP_READ && mem_addr == VA) seen = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        check_output("t6_reach_vec", seen, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_output("t6_async_ctl", ctl_vec(), 12'h0);
        check_output("t6_async_data", {mem_addr, mem_wdata}, 32'h0);
        check_output("t6_async_pcval", pc_load_value, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        busy_seen = 0;
        load_seen = 0;
        repeat (20) begin
            step();
            if (busy) busy_seen++;
            if (pc_load) load_seen++;
        end
        check_output("t6_no_busy", busy_seen, 0);
        check_output("t6_no_load", load_seen, 0);
        check_output("t6_in_isr", in_isr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
